// File: rtl/ppi_pkg.sv
// Shared types and encodings for the PPI handshake port.
package ppi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IN_EMPTY,
        ST_IN_FULL,
        ST_OUT_EMPTY,
        ST_OUT_BUSY
    } ppi_state_e;

    localparam logic MODE_BASIC   = 1'b0;
    localparam logic MODE_STROBED = 1'b1;
    localparam logic DIR_OUT      = 1'b0;
    localparam logic DIR_IN       = 1'b1;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/ppi_sync2.sv
// Two-flop synchroniser for an active-low async handshake pin, with a
// falling-edge pulse derived from the synchronised level.
module ppi_sync2
    import ppi_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign fall_o = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ppi_handshake_port.sv
// 8255-style programmable port with basic I/O and strobed handshake modes.
// Define PPI_PORT_FIFO_EN for a DEPTH-entry input FIFO instead of a single latch.
//
// state        | meaning
// ST_IDLE      | port disabled or basic mode
// ST_IN_EMPTY  | strobed input, buffer empty
// ST_IN_FULL   | strobed input, buffer holds data
// ST_OUT_EMPTY | strobed output, peripheral has taken data
// ST_OUT_BUSY  | strobed output, waiting for ack
module ppi_handshake_port
    import ppi_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             port_en,
    input  logic             mode,
    input  logic             dir,
    input  logic             inte,
    input  logic [WIDTH-1:0] cpu_wdata,
    input  logic             cpu_wr,
    input  logic             cpu_rd,
    output logic [WIDTH-1:0] cpu_rdata,
    input  logic [WIDTH-1:0] port_in,
    output logic [WIDTH-1:0] port_out,
    output logic             port_oe,
    input  logic             stb_n,
    input  logic             ack_n,
    output logic             ibf,
    output logic             obf_n,
    output logic             intr,
    output logic             ovr
);

`ifdef PPI_PORT_FIFO_EN
    localparam int BUF_DEPTH = DEPTH;
`else
    localparam int BUF_DEPTH = 1;
`endif
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(BUF_DEPTH);

    if (WIDTH < 1 || WIDTH > 32 || DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
        $error("ppi_handshake_port: WIDTH or DEPTH out of range");
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic stb_sync, stb_fall, ack_sync, ack_fall;

    ppi_sync2 u_sync_stb (.clk_i(clk), .rst_i(reset), .async_i(stb_n), .sync_o(stb_sync), .fall_o(stb_fall));
    ppi_sync2 u_sync_ack (.clk_i(clk), .rst_i(reset), .async_i(ack_n), .sync_o(ack_sync), .fall_o(ack_fall));

    ppi_state_e       state_q, state_d;
    logic [2:0]       cfg_q;
    logic [WIDTH-1:0] port_out_q, cpu_rdata_q;
    logic             port_oe_q, ibf_q, obf_n_q, intr_q, ovr_q, ack_seen_q;
    logic [WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             strobed, flush, in_active, pop, push, overrun;

    assign strobed   = port_en & (mode == MODE_STROBED);
    assign state_d   = !strobed ? ST_IDLE : ((dir == DIR_IN) ? ST_IN_EMPTY : ST_OUT_EMPTY);
    // Any config change (or sitting in IDLE) re-enters the empty state of the new config.
    assign flush     = ({port_en, mode, dir} != cfg_q) || (state_q == ST_IDLE);
    assign in_active = ((state_q == ST_IN_EMPTY) || (state_q == ST_IN_FULL)) && !flush;
    assign pop       = in_active && cpu_rd && (cnt_q != '0);
    assign push      = in_active && stb_fall && ((cnt_q != FULL_CNT) || pop);
    assign overrun   = in_active && stb_fall && !push;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= port_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cfg_q       <= '0;
            port_out_q  <= '0;
            cpu_rdata_q <= '0;
            port_oe_q   <= 1'b0;
            ibf_q       <= 1'b0;
            obf_n_q     <= 1'b1;
            intr_q      <= 1'b0;
            ovr_q       <= 1'b0;
            ack_seen_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            cfg_q     <= {port_en, mode, dir};
            port_oe_q <= port_en & (dir == DIR_OUT);
            if (cpu_rd) ovr_q <= 1'b0;

            if (!strobed) begin
                if (cpu_wr) port_out_q <= cpu_wdata;
                if (cpu_rd) cpu_rdata_q <= (dir == DIR_IN) ? port_in : port_out_q;
            end

            if (flush) begin
                state_q    <= state_d;
                ibf_q      <= 1'b0;
                obf_n_q    <= 1'b1;
                intr_q     <= 1'b0;
                ack_seen_q <= 1'b0;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                cnt_q      <= '0;
            end else begin
                intr_q <= inte & ((in_active & ibf_q & stb_sync) |
                                  ((state_q == ST_OUT_EMPTY) & obf_n_q & ack_sync & ack_seen_q));
                case (state_q)
                    ST_IN_EMPTY, ST_IN_FULL: begin
                        if (pop) begin
                            cpu_rdata_q <= mem_q[rd_ptr_q];
                            rd_ptr_q    <= ptr_inc(rd_ptr_q);
                        end
                        if (push)    wr_ptr_q <= ptr_inc(wr_ptr_q);
                        if (overrun) ovr_q    <= 1'b1;
                        cnt_q   <= cnt_d;
                        ibf_q   <= (cnt_d != '0);
                        state_q <= (cnt_d != '0) ? ST_IN_FULL : ST_IN_EMPTY;
                    end
                    ST_OUT_EMPTY, ST_OUT_BUSY: begin
                        if (cpu_rd) cpu_rdata_q <= port_out_q;
                        if (cpu_wr) begin
                            port_out_q <= cpu_wdata;
                            obf_n_q    <= 1'b0;
                            ack_seen_q <= 1'b0;
                            state_q    <= ST_OUT_BUSY;
                        end else if (ack_fall && state_q == ST_OUT_BUSY) begin
                            obf_n_q    <= 1'b1;
                            ack_seen_q <= 1'b1;
                            state_q    <= ST_OUT_EMPTY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign port_out  = port_out_q;
    assign port_oe   = port_oe_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ibf       = ibf_q;
    assign obf_n     = obf_n_q;
    assign intr      = intr_q;
    assign ovr       = ovr_q;

endmodule

// File: tb/tb_ppi_handshake_port.sv
// Directed bench for ppi_handshake_port; honours PPI_PORT_FIFO_EN for the overrun scenario.
module tb_ppi_handshake_port;

    logic       clk = 1'b0;
    logic       reset;
    logic       port_en, mode, dir, inte, cpu_wr, cpu_rd, stb_n, ack_n;
    logic [7:0] cpu_wdata, port_in;
    logic [7:0] cpu_rdata, port_out;
    logic       port_oe, ibf, obf_n, intr, ovr;

    int n_vec = 0;
    int n_err = 0;

    ppi_handshake_port #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .port_en(port_en), .mode(mode), .dir(dir), .inte(inte),
        .cpu_wdata(cpu_wdata), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_rdata(cpu_rdata),
        .port_in(port_in), .port_out(port_out), .port_oe(port_oe),
        .stb_n(stb_n), .ack_n(ack_n), .ibf(ibf), .obf_n(obf_n), .intr(intr), .ovr(ovr)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_write(input logic [7:0] d);
        cpu_wdata = d; cpu_wr = 1'b1; tick(); cpu_wr = 1'b0;
    endtask

    task automatic cpu_read();
        cpu_rd = 1'b1; tick(); cpu_rd = 1'b0;
    endtask

    task automatic pulse_stb(input logic [7:0] d, input int low);
        port_in = d; stb_n = 1'b0; tick(low); stb_n = 1'b1; tick(3);
    endtask

    task automatic test_reset();
        tick(2);
        n_vec++; if (port_out !== 8'h00) begin n_err++; $display("FAIL rst_port_out: got %h want %h", port_out, 8'h00); end
        n_vec++; if (port_oe !== 1'b0) begin n_err++; $display("FAIL rst_port_oe: got %b want 0", port_oe); end
        n_vec++; if (cpu_rdata !== 8'h00) begin n_err++; $display("FAIL rst_rdata: got %h want 00", cpu_rdata); end
        n_vec++; if ({ibf, obf_n, intr, ovr} !== 4'b0100) begin n_err++; $display("FAIL rst_flags: got %b want 0100", {ibf, obf_n, intr, ovr}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_mode0();
        port_en = 1'b1; mode = 1'b0; dir = 1'b0;
        tick();
        cpu_write(8'hA5);
        n_vec++; if (port_out !== 8'hA5) begin n_err++; $display("FAIL m0_port_out: got %h want a5", port_out); end
        n_vec++; if (port_oe !== 1'b1) begin n_err++; $display("FAIL m0_port_oe: got %b want 1", port_oe); end
        n_vec++; if ({ibf, obf_n, intr} !== 3'b010) begin n_err++; $display("FAIL m0_flags: got %b want 010", {ibf, obf_n, intr}); end
        cpu_read();
        n_vec++; if (cpu_rdata !== 8'hA5) begin n_err++; $display("FAIL m0_rd_out: got %h want a5", cpu_rdata); end
        dir = 1'b1; port_in = 8'h5A;
        tick();
        n_vec++; if (port_oe !== 1'b0) begin n_err++; $display("FAIL m0_oe_in: got %b want 0", port_oe); end
        cpu_read();
        n_vec++; if (cpu_rdata !== 8'h5A) begin n_err++; $display("FAIL m0_rd_in: got %h want 5a", cpu_rdata); end
        n_vec++; if (port_out !== 8'hA5) begin n_err++; $display("FAIL m0_out_keep: got %h want a5", port_out); end
    endtask

    task automatic test_input();
        mode = 1'b1; inte = 1'b1; port_in = 8'h3C;
        tick();
        stb_n = 1'b0;
        tick(2);
        n_vec++; if (ibf !== 1'b0) begin n_err++; $display("FAIL in_ibf_early: got %b want 0", ibf); end
        tick();
        n_vec++; if (ibf !== 1'b1) begin n_err++; $display("FAIL in_ibf_set: got %b want 1", ibf); end
        n_vec++; if (intr !== 1'b0) begin n_err++; $display("FAIL in_intr_stb_low: got %b want 0", intr); end
        tick();
        stb_n = 1'b1;
        tick(2);
        n_vec++; if (intr !== 1'b0) begin n_err++; $display("FAIL in_intr_early: got %b want 0", intr); end
        tick();
        n_vec++; if (intr !== 1'b1) begin n_err++; $display("FAIL in_intr_set: got %b want 1", intr); end
        cpu_read();
        n_vec++; if (cpu_rdata !== 8'h3C) begin n_err++; $display("FAIL in_rdata: got %h want 3c", cpu_rdata); end
        n_vec++; if (ibf !== 1'b0) begin n_err++; $display("FAIL in_ibf_clr: got %b want 0", ibf); end
        tick();
        n_vec++; if (intr !== 1'b0) begin n_err++; $display("FAIL in_intr_clr: got %b want 0", intr); end
        n_vec++; if (ovr !== 1'b0) begin n_err++; $display("FAIL in_ovr: got %b want 0", ovr); end
    endtask

    task automatic test_overrun();
`ifdef PPI_PORT_FIFO_EN
        for (int i = 1; i <= 5; i++) pulse_stb(8'(i), 3);
        n_vec++; if (ovr !== 1'b1) begin n_err++; $display("FAIL ovr_fifo_set: got %b want 1", ovr); end
        for (int i = 1; i <= 4; i++) begin
            cpu_read();
            n_vec++; if (cpu_rdata !== 8'(i)) begin n_err++; $display("FAIL ovr_fifo_rd%0d: got %h want %h", i, cpu_rdata, 8'(i)); end
        end
        n_vec++; if (ibf !== 1'b0) begin n_err++; $display("FAIL ovr_fifo_ibf: got %b want 0", ibf); end
`else
        pulse_stb(8'h11, 3);
        pulse_stb(8'h22, 3);
        n_vec++; if (ovr !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b want 1", ovr); end
        n_vec++; if (ibf !== 1'b1) begin n_err++; $display("FAIL ovr_ibf: got %b want 1", ibf); end
        cpu_read();
        n_vec++; if (cpu_rdata !== 8'h11) begin n_err++; $display("FAIL ovr_rdata: got %h want 11", cpu_rdata); end
        n_vec++; if (ibf !== 1'b0) begin n_err++; $display("FAIL ovr_ibf_clr: got %b want 0", ibf); end
`endif
        n_vec++; if (ovr !== 1'b0) begin n_err++; $display("FAIL ovr_clr: got %b want 0", ovr); end
    endtask

    task automatic test_simul_rd_stb();
        pulse_stb(8'h44, 3);
        port_in = 8'h55; stb_n = 1'b0;
        tick(2);
        cpu_read();
        n_vec++; if (cpu_rdata !== 8'h44) begin n_err++; $display("FAIL sim_rdata: got %h want 44", cpu_rdata); end
        n_vec++; if (ibf !== 1'b1) begin n_err++; $display("FAIL sim_ibf: got %b want 1", ibf); end
        n_vec++; if (ovr !== 1'b0) begin n_err++; $display("FAIL sim_ovr: got %b want 0", ovr); end
        stb_n = 1'b1;
        tick(3);
        cpu_read();
        n_vec++; if (cpu_rdata !== 8'h55) begin n_err++; $display("FAIL sim_rdata2: got %h want 55", cpu_rdata); end
        n_vec++; if (ibf !== 1'b0) begin n_err++; $display("FAIL sim_ibf2: got %b want 0", ibf); end
    endtask

    task automatic test_flush();
        pulse_stb(8'h66, 3);
        n_vec++; if (ibf !== 1'b1) begin n_err++; $display("FAIL fl_pre_ibf: got %b want 1", ibf); end
        dir = 1'b0;
        tick();
        n_vec++; if (ibf !== 1'b0) begin n_err++; $display("FAIL fl_ibf: got %b want 0", ibf); end
        n_vec++; if (port_out !== 8'hA5) begin n_err++; $display("FAIL fl_port_out: got %h want a5", port_out); end
        n_vec++; if (port_oe !== 1'b1) begin n_err++; $display("FAIL fl_port_oe: got %b want 1", port_oe); end
    endtask

    task automatic test_output();
        tick();
        n_vec++; if (obf_n !== 1'b1) begin n_err++; $display("FAIL out_obf_idle: got %b want 1", obf_n); end
        cpu_write(8'h81);
        n_vec++; if (obf_n !== 1'b0) begin n_err++; $display("FAIL out_obf_set: got %b want 0", obf_n); end
        n_vec++; if (port_out !== 8'h81) begin n_err++; $display("FAIL out_data: got %h want 81", port_out); end
        cpu_write(8'h82);
        n_vec++; if ({port_out, obf_n} !== {8'h82, 1'b0}) begin n_err++; $display("FAIL out_overwrite: got %h/%b want 82/0", port_out, obf_n); end
        ack_n = 1'b0;
        tick(2);
        n_vec++; if (obf_n !== 1'b0) begin n_err++; $display("FAIL out_obf_early: got %b want 0", obf_n); end
        tick();
        n_vec++; if (obf_n !== 1'b1) begin n_err++; $display("FAIL out_obf_ack: got %b want 1", obf_n); end
        ack_n = 1'b1;
        tick(2);
        n_vec++; if (intr !== 1'b0) begin n_err++; $display("FAIL out_intr_early: got %b want 0", intr); end
        tick();
        n_vec++; if (intr !== 1'b1) begin n_err++; $display("FAIL out_intr_set: got %b want 1", intr); end
        cpu_write(8'h90);
        n_vec++; if (obf_n !== 1'b0) begin n_err++; $display("FAIL out_obf_wr2: got %b want 0", obf_n); end
        tick();
        n_vec++; if (intr !== 1'b0) begin n_err++; $display("FAIL out_intr_clr: got %b want 0", intr); end
    endtask

    task automatic test_reset_mid();
        #2;
        reset = 1'b1;
        #1;
        n_vec++; if (obf_n !== 1'b1) begin n_err++; $display("FAIL rm_obf_n: got %b want 1", obf_n); end
        n_vec++; if (port_oe !== 1'b0) begin n_err++; $display("FAIL rm_port_oe: got %b want 0", port_oe); end
        n_vec++; if ({intr, port_out} !== 9'h000) begin n_err++; $display("FAIL rm_intr_out: got %b/%h want 0/00", intr, port_out); end
        tick();
        reset = 1'b0;
        tick(5);
        n_vec++; if ({intr, obf_n, port_oe} !== 3'b011) begin n_err++; $display("FAIL rm_release: got %b want 011", {intr, obf_n, port_oe}); end
    endtask

    initial begin
        reset = 1'b1; port_en = 1'b0; mode = 1'b0; dir = 1'b0; inte = 1'b0;
        cpu_wdata = '0; cpu_wr = 1'b0; cpu_rd = 1'b0; port_in = '0; stb_n = 1'b1; ack_n = 1'b1;
        test_reset();
        test_mode0();
        test_input();
        test_overrun();
        test_simul_rd_stb();
        test_flush();
        test_output();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ppi_handshake_port.md
PPI_HANDSHAKE_PORT -- requirements
Module: ppi_handshake_port

Interface
REQ-001 Parameter WIDTH, default 8, port data width in bits (1..32).
REQ-002 Parameter DEPTH, default 4, input FIFO entries (power of two, 2..16); used only with PPI_PORT_FIFO_EN.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 port_en  input  1  port activate; 0 = port idle, port_oe forced 0.
REQ-006 mode  input  1  0 = basic I/O, 1 = strobed handshake.
REQ-007 dir  input  1  0 = output, 1 = input.
REQ-008 inte  input  1  interrupt enable.
REQ-009 cpu_wdata  input  WIDTH  CPU write data.
REQ-010 cpu_wr / cpu_rd  input  1 each  single-cycle CPU write / read strobes.
REQ-011 cpu_rdata  output  WIDTH  registered CPU read data.
REQ-012 port_in  input  WIDTH  pin data in; port_out  output  WIDTH  pin data out; port_oe  output  1  pin driver enable (tristate at top level).
REQ-013 stb_n / ack_n  input  1 each  asynchronous peripheral strobe / acknowledge, active-low.
REQ-014 ibf, obf_n, intr, ovr  output  1 each  input-buffer-full, output-buffer-full (active-low), interrupt, sticky overrun.

Function
REQ-015 stb_n and ack_n SHALL pass 2-flop synchronisers; edges detected on synchronised value (falling edge seen 3rd clk after pin change).
REQ-016 Mode 0: port_oe = port_en & ~dir; cpu_wr latches cpu_wdata into port_out next cycle; cpu_rd loads cpu_rdata with port_in (dir=1) or port_out (dir=0) next cycle; ibf=0, obf_n=1, intr=0.
REQ-017 Mode 1 FSM states: IDLE, IN_EMPTY, IN_FULL, OUT_EMPTY, OUT_BUSY; IDLE when port_en=0 or mode=0.
REQ-018 IN_EMPTY: detected stb_n fall captures port_in, ibf=1 next cycle, -> IN_FULL.
REQ-019 IN_FULL: cpu_rd returns oldest data next cycle, ibf cleared when buffer empties, -> IN_EMPTY; stb_n fall while full discards data and sets ovr.
REQ-020 Simultaneous stb_n fall and cpu_rd: read serviced first, then capture; no ovr.
REQ-021 OUT_EMPTY: cpu_wr latches port_out, obf_n=0 next cycle, -> OUT_BUSY; port_oe=1 throughout dir=0.
REQ-022 OUT_BUSY: detected ack_n fall sets obf_n=1, -> OUT_EMPTY; cpu_wr in OUT_BUSY overwrites port_out, obf_n stays 0.
REQ-023 intr = inte & (input: ibf & stb_n_sync) | (output: obf_n & ack_n_sync & ack-seen flag); ack-seen cleared by cpu_wr; registered, 1 cycle after condition.
REQ-024 ovr cleared by cpu_rd.
REQ-025 Change of mode, dir or port_en SHALL flush buffer and enter IDLE/empty state next cycle; port_out retained.

Reset
REQ-026 reset SHALL asynchronously force: port_out=0, port_oe=0, cpu_rdata=0, ibf=0, obf_n=1, intr=0, ovr=0, FIFO empty, synchronisers to 1, FSM IDLE.
REQ-027 reset mid-handshake abandons transfer; no intr on release.

Configuration
REQ-028 Macro PPI_PORT_FIFO_EN defined: input path uses DEPTH-entry FIFO, ibf=1 while non-empty, ovr on strobe when full.
REQ-029 Macro undefined: single input latch (DEPTH ignored), 8255-compatible; ovr on strobe while ibf=1.

Structure
REQ-030 Shared package ppi_pkg SHALL hold FSM state typedef, mode/dir encodings and synchroniser stage count.
REQ-031 Sub-module ppi_sync2 (2-flop synchroniser with falling-edge output) SHALL be instantiated for stb_n and ack_n.

Verification
REQ-032 Mode 0, dir=0, cpu_wr 0xA5 -> port_out=0xA5, port_oe=1 next cycle.
REQ-033 Mode 1 input, inte=1, port_in=0x3C, pulse stb_n low 4 clk -> ibf=1, intr=1 after stb_n high; cpu_rd -> cpu_rdata=0x3C, ibf=0, intr=0.
REQ-034 Mode 1 output, inte=1, cpu_wr 0x81 -> obf_n=0; ack_n pulse -> obf_n=1, intr=1; next cpu_wr clears intr.
REQ-035 Without FIFO: two strobes (0x11, 0x22) no read -> ovr=1, cpu_rd returns 0x11; with FIFO DEPTH=4: five strobes -> reads 1..4 in order, ovr=1.
REQ-036 Assert reset during OUT_BUSY -> obf_n=1, port_oe=0, intr=0 immediately, no clock needed.
